relu2_stage: RTL and testbench
==============================

# relu2_stage

Activation stage directly downstream of the layer-2 matrix-multiply result memory (64 × 32-bit signed). On a start pulse it streams all elements out of that memory, applies ReLU (and an optional fixed-point rescale), and writes the results into the next layer's input memory. It issues one read per cycle and works with a synchronous memory whose read data is valid one cycle after the address is presented.

## Interface
Parameters:
- NUM_ELEMENTS, 64, number of elements processed per run
- DATA_WIDTH, 32, signed element width
- ADDR_WIDTH, 16, address width on both memory ports
- FRAC_SHIFT, 8, arithmetic right-shift amount, used only when RELU2_SHIFT_EN is defined

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a run; sampled only in IDLE
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse after the last write
- read_addr  out  ADDR_WIDTH  address to the upstream result memory
- data_in  in  signed DATA_WIDTH  upstream memory data_out (registered, 1-cycle latency)
- write_addr  out  ADDR_WIDTH  address to the downstream memory
- data_out  out  signed DATA_WIDTH  activation result
- write_enable  out  1  downstream write strobe

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1. On this transition: read_addr<=0, busy<=1, and the read counter is cleared.
- RUN: read_addr increments by 1 every cycle up to NUM_ELEMENTS-1. After issuing NUM_ELEMENTS-1, the block moves to DRAIN.
- DRAIN: the block issues no new reads. It waits until the 2-stage valid pipeline is empty, then moves to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. DONE does not sample start.
- Valid pipeline:
  - stage 1 marks that an address was issued;
  - stage 2 marks that data_in is valid for that address and carries the delayed address.
- Output register: when stage 2 is valid, write_enable<=1, write_addr<=delayed address, data_out<=f(data_in). Otherwise write_enable<=0.
- Activation function f(x): 0 when x[DATA_WIDTH-1]=1, otherwise x. Exactly 0 passes through as 0.
- read_addr holds its last value in DRAIN, DONE and IDLE. write_addr and data_out hold their last value when write_enable=0.
- start while busy (RUN, DRAIN or DONE) is ignored. It is neither queued nor allowed to restart the run.
- Addresses never exceed NUM_ELEMENTS-1. No wrap-around occurs within a run.

## Timing
- Reset values: busy=0, done=0, write_enable=0, read_addr=0, write_addr=0, data_out=0. The FSM resets to IDLE and the pipeline valids to 0.
- The reset is asynchronous. Asserting rst_n=0 mid-run aborts immediately: outputs go to their reset values and no partial done is produced. Only writes already strobed have occurred.
- Cycle numbering: edge 0 is the edge at which start=1 is sampled in IDLE.
  - Read address i is driven after edge i.
  - data_in for element i is valid after edge i+1.
  - write_enable for element i is high between edges i+2 and i+3.
- Throughput is one element per cycle. For NUM_ELEMENTS=64, write_enable is high continuously from edge 2 to edge 66.
- done is high between edges 66 and 67. busy is high from edge 0 to edge 66.
- Total latency from start to done: NUM_ELEMENTS+2 cycles.
- A new start can be accepted at edge 67 at the earliest.

## Configuration
- Macro RELU2_SHIFT_EN.
- Defined: f(x) = 0 when x<0, otherwise x >>> FRAC_SHIFT. This is an arithmetic shift of the non-negative value, with the upper bits zero-filled. It rescales the fixed-point product back to input scale. Latency is unchanged.
- Undefined: f(x) is plain ReLU. FRAC_SHIFT is unused.

## Test plan
- Reset, then hold start=0 for 10 cycles -> all outputs stay at reset values and write_enable is never asserted.
- Preload the upstream memory with mem[0]=32'hFFFFFFFF, mem[1]=32'h00000005, mem[2]=32'h80000000, mem[3]=32'h7FFFFFFF, mem[4]=0, and mem[i]=i for the rest. Pulse start -> downstream receives 0, 5, 0, 7FFFFFFF, 0, then i at address i. There are exactly 64 writes at addresses 0..63, in order.
- Same run, check cycles -> the first write_enable appears 2 cycles after the start edge, with no gaps. done pulses once at start+66 and busy deasserts in the same cycle.
- Pulse start again at start+10 during a run -> it is ignored: no extra writes and a single done. A start at start+67 begins a second identical run.
- Drop rst_n low at start+30 -> outputs clear asynchronously, only addresses 0..27 have been written, and no done occurs. After release, a new start completes a full run.
- With RELU2_SHIFT_EN defined and FRAC_SHIFT=8: mem[0]=32'h00001234 -> 32'h00000012, mem[1]=32'hFFFF0000 -> 0, and mem[2]=32'h7FFFFFFF -> 32'h007FFFFF.

Source files
------------

// File: rtl/relu2_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : relu2_stage_if
//  Description : Control handshake plus upstream-read / downstream-write bus
//                of the layer-2 activation stage. The slave modport is the
//                activation stage; the master modport is the controller and
//                memory side that drives start and the upstream read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface relu2_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);

    // Run control
    logic                         start;
    logic                         busy;
    logic                         done;

    // Upstream result memory (synchronous read, 1-cycle latency)
    logic [ADDR_WIDTH-1:0]        read_addr;
    logic signed [DATA_WIDTH-1:0] data_in;

    // Downstream input memory write port
    logic [ADDR_WIDTH-1:0]        write_addr;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         write_enable;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  read_addr,
        input  write_addr,
        input  data_out,
        input  write_enable
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output read_addr,
        output write_addr,
        output data_out,
        output write_enable
    );

endinterface
`default_nettype wire

// File: rtl/relu2_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : relu2_stage
//  Description : Streams NUM_ELEMENTS words out of the layer-2 result memory,
//                applies ReLU and writes the results to the next layer's
//                input memory at one element per cycle.
//                Optional feature macro RELU2_SHIFT_EN: when defined, positive
//                values are also arithmetically shifted right by FRAC_SHIFT
//                to rescale the fixed-point product back to input scale.
//  Revision    : 1.0  initial release
// ============================================================================
module relu2_stage #(
    parameter int NUM_ELEMENTS = 64,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int FRAC_SHIFT   = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    relu2_stage_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(NUM_ELEMENTS - 1);

`ifdef RELU2_SHIFT_EN
    localparam int c_SHIFT_ON = 1;
`else
    localparam int c_SHIFT_ON = 0;
`endif

    // Plain ReLU is the same datapath with a zero shift amount.
    localparam int c_SHIFT = FRAC_SHIFT * c_SHIFT_ON;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       r_state;

    // read_addr doubles as the read counter: it is the index of the element
    // whose address is currently presented to the upstream memory.
    logic [ADDR_WIDTH-1:0]        r_read_addr;
    logic                         r_busy;
    logic                         r_done;

    // Valid pipeline: stage 1 = address issued this cycle,
    // stage 2 = data_in valid for r_s2_addr.
    logic                         r_s1_valid;
    logic                         r_s2_valid;
    logic [ADDR_WIDTH-1:0]        r_s2_addr;

    // Output register
    logic                         r_write_enable;
    logic [ADDR_WIDTH-1:0]        r_write_addr;
    logic signed [DATA_WIDTH-1:0] r_data_out;

    // Activation result for the word currently on data_in
    logic signed [DATA_WIDTH-1:0] w_act;

    // ------------------------------------------------------------------------
    // Run control FSM and read-address generation (all outputs registered).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_read_addr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_s1_valid  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_s1_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Element 0 is issued on the accepting edge itself.
                        r_read_addr <= '0;
                        r_s1_valid  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= (c_LAST_ADDR == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    r_read_addr <= r_read_addr + 1'b1;
                    r_s1_valid  <= 1'b1;
                    if (r_read_addr == c_LAST_ADDR - 1'b1) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Once stage 1 is empty, the last element sits in stage 2
                    // and moves into the output register on this same edge,
                    // so the pipeline is empty when DONE is reached.
                    if (!r_s1_valid) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // done/busy are registered, so they change one cycle after
                    // this state is entered; that lets the following IDLE
                    // accept a new start while done is still high.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Second valid stage: aligns the issued address with the memory's
    // one-cycle read latency.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_read_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Activation: negative inputs clamp to zero; non-negative inputs pass
    // through, shifted by c_SHIFT (zero when rescaling is disabled). The sign
    // bit of a non-negative value is 0, so the arithmetic shift zero-fills.
    // ------------------------------------------------------------------------
    always_comb begin
        w_act = '0;
        if (!bus.data_in[DATA_WIDTH-1]) begin
            w_act = bus.data_in >>> c_SHIFT;
        end
    end

    // ------------------------------------------------------------------------
    // Output register: strobe a write whenever stage 2 holds valid data;
    // address and data hold their previous values between writes.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_enable <= 1'b0;
            r_write_addr   <= '0;
            r_data_out     <= '0;
        end else begin
            r_write_enable <= r_s2_valid;
            if (r_s2_valid) begin
                r_write_addr <= r_s2_addr;
                r_data_out   <= w_act;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Port mapping
    // ------------------------------------------------------------------------
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.read_addr    = r_read_addr;
    assign bus.write_enable = r_write_enable;
    assign bus.write_addr   = r_write_addr;
    assign bus.data_out     = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_relu2_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_relu2_stage
//  Description : Self-checking bench for relu2_stage. An upstream memory model
//                feeds the stage; a monitor records every downstream write and
//                done pulse with its cycle number; each test compares against
//                expectations derived from the activation rule and the
//                documented cycle timing. Honours RELU2_SHIFT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_relu2_stage;

    localparam int N  = 64;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int FS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    relu2_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    relu2_stage #(
        .NUM_ELEMENTS (N),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .FRAC_SHIFT   (FS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Upstream memory: synchronous read, data valid one cycle after address.
    logic [DW-1:0] mem [N];
    always @(posedge clk) bus.data_in <= mem[bus.read_addr[5:0]];

    // Cycle counter: value seen between edges c and c+1 is c.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor of the downstream write port and done.
    int            wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            wc_q [$];
    int            done_q [$];
    logic          busy_log [1024];

    always @(negedge clk) begin
        busy_log[cyc % 1024] <= bus.busy;
        if (bus.write_enable) begin
            wa_q.push_back(int'(bus.write_addr));
            wd_q.push_back(bus.data_out);
            wc_q.push_back(cyc);
        end
        if (bus.done) done_q.push_back(cyc);
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference activation from the arithmetic definition.
    function automatic logic [DW-1:0] ref_f(input logic [DW-1:0] raw);
        longint v;
        v = longint'(signed'(raw));
        if (v < 0) return '0;
`ifdef RELU2_SHIFT_EN
        return DW'(v / (longint'(1) << FS));
`else
        return DW'(v);
`endif
    endfunction

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_q.delete();
    endtask

    // Raise start so that edge c+1 samples it.
    task automatic drive_start_after(input int c);
        while (cyc < c) @(negedge clk);
        #1 bus.start = 1'b1;
        @(negedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic pulse_start(output int se);
        @(negedge clk);
        se = cyc + 1;
        drive_start_after(cyc);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int active = 0;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", bus.done); else n_pass++;
        n_total++; if (bus.write_enable !== 1'b0) $display("FAIL reset_we: got %0b expected 0", bus.write_enable); else n_pass++;
        n_total++; if (bus.read_addr !== '0) $display("FAIL reset_read_addr: got %0d expected 0", bus.read_addr); else n_pass++;
        n_total++; if (bus.write_addr !== '0) $display("FAIL reset_write_addr: got %0d expected 0", bus.write_addr); else n_pass++;
        n_total++; if (bus.data_out !== '0) $display("FAIL reset_data_out: got %h expected 0", bus.data_out); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.write_enable || bus.busy || bus.done) active++;
        end
        n_total++; if (active !== 0) $display("FAIL idle_activity: got %0d active cycles expected 0", active); else n_pass++;
        n_total++; if (bus.read_addr !== '0 || bus.write_addr !== '0 || bus.data_out !== '0)
            $display("FAIL idle_outputs: got ra=%0d wa=%0d d=%h expected 0 0 0", bus.read_addr, bus.write_addr, bus.data_out);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_directed();
        logic [DW-1:0] expd [N];
        int se, d0, busy_hi;
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
`ifdef RELU2_SHIFT_EN
        mem[0] = 32'h00001234; mem[1] = 32'hFFFF0000; mem[2] = 32'h7FFFFFFF;
        mem[3] = 32'h80000000; mem[4] = 32'h0;
        for (int i = 0; i < N; i++) expd[i] = 32'h0;   // i < 256 shifts to 0
        expd[0] = 32'h00000012; expd[2] = 32'h007FFFFF;
`else
        mem[0] = 32'hFFFFFFFF; mem[1] = 32'h00000005; mem[2] = 32'h80000000;
        mem[3] = 32'h7FFFFFFF; mem[4] = 32'h0;
        for (int i = 0; i < N; i++) expd[i] = DW'(i);
        expd[0] = 32'h0; expd[1] = 32'h5; expd[2] = 32'h0; expd[3] = 32'h7FFFFFFF; expd[4] = 32'h0;
`endif
        clear_mon();
        pulse_start(se);
        repeat (75) @(negedge clk);
        n_total++; if (wa_q.size() !== N) $display("FAIL directed_count: got %0d writes expected %0d", wa_q.size(), N); else n_pass++;
        for (int k = 0; k < wa_q.size() && k < N; k++) begin
            n_total++;
            if (wa_q[k] !== k || wd_q[k] !== expd[k] || wc_q[k] - se !== k + 2)
                $display("FAIL directed_write[%0d]: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         k, wa_q[k], wd_q[k], wc_q[k] - se, k, expd[k], k + 2);
            else n_pass++;
        end
        d0 = (done_q.size() > 0) ? done_q[0] - se : -1;
        n_total++; if (done_q.size() !== 1) $display("FAIL directed_done_count: got %0d expected 1", done_q.size()); else n_pass++;
        n_total++; if (d0 !== N + 2) $display("FAIL directed_done_cycle: got %0d expected %0d", d0, N + 2); else n_pass++;
        busy_hi = 0;
        for (int c = 0; c <= N + 1; c++) if (busy_log[(se + c) % 1024] === 1'b1) busy_hi++;
        n_total++; if (busy_hi !== N + 2) $display("FAIL directed_busy_high: got %0d cycles expected %0d", busy_hi, N + 2); else n_pass++;
        n_total++; if (busy_log[(se + N + 2) % 1024] !== 1'b0) $display("FAIL directed_busy_drop: got %0b expected 0", busy_log[(se + N + 2) % 1024]); else n_pass++;
        n_total++; if (bus.read_addr !== AW'(N - 1)) $display("FAIL directed_read_hold: got %0d expected %0d", bus.read_addr, N - 1); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        int se;
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        clear_mon();
        pulse_start(se);
        repeat (75) @(negedge clk);
        n_total++; if (wa_q.size() !== N) $display("FAIL random_count: got %0d expected %0d", wa_q.size(), N); else n_pass++;
        for (int k = 0; k < wa_q.size() && k < N; k++) begin
            n_total++;
            if (wa_q[k] !== k || wd_q[k] !== ref_f(mem[k]) || wc_q[k] - se !== k + 2)
                $display("FAIL random_write[%0d]: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         k, wa_q[k], wd_q[k], wc_q[k] - se, k, ref_f(mem[k]), k + 2);
            else n_pass++;
        end
        n_total++; if (done_q.size() !== 1) $display("FAIL random_done_count: got %0d expected 1", done_q.size()); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int se, se2, run, idx;
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        clear_mon();
        pulse_start(se);
        drive_start_after(se + 9);          // sampled at start+10: must be ignored
        drive_start_after(se + N + 2);      // sampled at start+67: second run
        se2 = se + N + 3;
        repeat (75) @(negedge clk);
        n_total++; if (wa_q.size() !== 2 * N) $display("FAIL b2b_count: got %0d expected %0d", wa_q.size(), 2 * N); else n_pass++;
        for (int k = 0; k < wa_q.size() && k < 2 * N; k++) begin
            run = k / N;
            idx = k % N;
            n_total++;
            if (wa_q[k] !== idx || wd_q[k] !== ref_f(mem[idx]) || wc_q[k] - (run ? se2 : se) !== idx + 2)
                $display("FAIL b2b_write[%0d]: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         k, wa_q[k], wd_q[k], wc_q[k] - (run ? se2 : se), idx, ref_f(mem[idx]), idx + 2);
            else n_pass++;
        end
        n_total++; if (done_q.size() !== 2) $display("FAIL b2b_done_count: got %0d expected 2", done_q.size()); else n_pass++;
        n_total++; if (done_q.size() !== 2 || done_q[0] - se !== N + 2 || done_q[1] - se2 !== N + 2)
            $display("FAIL b2b_done_cycles: got %0d pulses expected 2 at +%0d each", done_q.size(), N + 2);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_run();
        int se;
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        clear_mon();
        pulse_start(se);
        while (cyc < se + 29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.busy !== 1'b0 || bus.write_enable !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL abort_ctrl: got busy=%0b we=%0b done=%0b expected 0 0 0", bus.busy, bus.write_enable, bus.done);
        else n_pass++;
        n_total++; if (bus.read_addr !== '0 || bus.write_addr !== '0 || bus.data_out !== '0)
            $display("FAIL abort_data: got ra=%0d wa=%0d d=%h expected 0 0 0", bus.read_addr, bus.write_addr, bus.data_out);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (75) @(negedge clk);
        n_total++; if (wa_q.size() !== 28) $display("FAIL abort_count: got %0d writes expected 28", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size() && k < N; k++) begin
            n_total++;
            if (wa_q[k] !== k || wd_q[k] !== ref_f(mem[k]))
                $display("FAIL abort_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h", k, wa_q[k], wd_q[k], k, ref_f(mem[k]));
            else n_pass++;
        end
        n_total++; if (done_q.size() !== 0) $display("FAIL abort_done: got %0d pulses expected 0", done_q.size()); else n_pass++;

        clear_mon();
        pulse_start(se);
        repeat (75) @(negedge clk);
        n_total++; if (wa_q.size() !== N) $display("FAIL rerun_count: got %0d expected %0d", wa_q.size(), N); else n_pass++;
        for (int k = 0; k < wa_q.size() && k < N; k++) begin
            n_total++;
            if (wa_q[k] !== k || wd_q[k] !== ref_f(mem[k]) || wc_q[k] - se !== k + 2)
                $display("FAIL rerun_write[%0d]: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         k, wa_q[k], wd_q[k], wc_q[k] - se, k, ref_f(mem[k]), k + 2);
            else n_pass++;
        end
        n_total++; if (done_q.size() !== 1) $display("FAIL rerun_done: got %0d expected 1", done_q.size()); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
